// File: rtl/tge_frame_packer_if.sv
// Sample input stream and packed 128-bit output stream of the frame packer.
interface tge_frame_packer_if;
    localparam int unsigned DIN_W  = 32;
    localparam int unsigned DOUT_W = 128;

    logic [DIN_W-1:0]  din;
    logic              din_valid;
    logic [DOUT_W-1:0] dout;
    logic              dout_valid;
    logic              dout_sof;
    logic              dout_eof;

    // Sample source / output sink side
    modport master (
        output din, din_valid,
        input  dout, dout_valid, dout_sof, dout_eof
    );

    // Packer side
    modport slave (
        input  din, din_valid,
        output dout, dout_valid, dout_sof, dout_eof
    );
endinterface

// File: rtl/tge_frame_packer.sv
// Packs 32-bit samples into 128-bit words, prefixing each packet with a
// {MAGIC, seq_num, timestamp} header word. Framing starts on sync_in.
module tge_frame_packer (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic                   sync_in,
    input  logic [15:0]            words_per_pkt,
    output logic [31:0]            seq_num,
    output logic                   sync_err,
    tge_frame_packer_if.slave      bus
);
    localparam int unsigned TS_W   = 64;
    localparam int unsigned SEQ_W  = 32;
    localparam int unsigned LEN_W  = 16;
    localparam int unsigned ACC_W  = 96;
    localparam int unsigned DOUT_W = 128;
    localparam logic [31:0] MAGIC  = 32'hF2B0_0001;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_SYNC = 2'd1,
        ST_RUN       = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [TS_W-1:0]     ts_q, ts_d;
    logic [1:0]          lane_q, lane_d;
    logic [LEN_W-1:0]    word_q, word_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [SEQ_W-1:0]    seq_q, seq_d;
    logic                err_q, err_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [DOUT_W-1:0]   dout_q, dout_d;
    logic                valid_q, valid_d;
    logic                sof_q, sof_d;
    logic                eof_q, eof_d;

    logic                sync_start;
    logic                accept;
    logic [TS_W-1:0]     ts_now;
    logic [SEQ_W-1:0]    seq_now;
    logic [1:0]          lane_now;
    logic [LEN_W-1:0]    word_now;

    // Next-state, packing and output word selection
    always_comb begin
        state_d    = state_q;
        lane_d     = lane_q;
        word_d     = word_q;
        len_d      = len_q;
        seq_d      = seq_q;
        err_d      = err_q;
        acc_d      = acc_q;
        dout_d     = dout_q;
        valid_d    = 1'b0;
        sof_d      = 1'b0;
        eof_d      = 1'b0;
        sync_start = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (enable) state_d = ST_WAIT_SYNC;
            end
            ST_WAIT_SYNC: begin
                if (enable && sync_in) begin
                    sync_start = 1'b1;
                    state_d    = ST_RUN;
                end else if (!enable) begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                // A sync anywhere but a packet boundary means lost alignment
                if (sync_in && !(lane_q == 2'd0 && word_q == LEN_W'(0))) err_d = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase

        // The sync cycle sees freshly cleared counters
        ts_now   = sync_start ? TS_W'(0)  : ts_q;
        seq_now  = sync_start ? SEQ_W'(0) : seq_q;
        lane_now = sync_start ? 2'd0      : lane_q;
        word_now = sync_start ? LEN_W'(0) : word_q;
        ts_d     = ts_now + TS_W'(1);
        seq_d    = sync_start ? SEQ_W'(0) : seq_d;
        lane_d   = lane_now;
        word_d   = word_now;

        accept = bus.din_valid && ((state_q == ST_RUN) || sync_start);

        if (accept) begin
            if (lane_now == 2'd0 && word_now == LEN_W'(0)) begin
                dout_d  = {MAGIC, seq_now, ts_now};
                valid_d = 1'b1;
                sof_d   = 1'b1;
                len_d   = (words_per_pkt == LEN_W'(0)) ? LEN_W'(1) : words_per_pkt;
            end
            case (lane_now)
                2'd0: acc_d[95:64] = bus.din;
                2'd1: acc_d[63:32] = bus.din;
                2'd2: acc_d[31:0]  = bus.din;
                default: begin
                    dout_d  = {acc_q, bus.din};
                    valid_d = 1'b1;
                    if (word_now == len_q - LEN_W'(1)) begin
                        eof_d  = 1'b1;
                        word_d = LEN_W'(0);
                        seq_d  = seq_now + SEQ_W'(1);
                        if (!enable) state_d = ST_IDLE;
                    end else begin
                        word_d = word_now + LEN_W'(1);
                    end
                end
            endcase
            lane_d = lane_now + 2'd1;
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ts_q    <= '0;
            lane_q  <= '0;
            word_q  <= '0;
            len_q   <= '0;
            seq_q   <= '0;
            err_q   <= 1'b0;
            acc_q   <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            sof_q   <= 1'b0;
            eof_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ts_q    <= ts_d;
            lane_q  <= lane_d;
            word_q  <= word_d;
            len_q   <= len_d;
            seq_q   <= seq_d;
            err_q   <= err_d;
            acc_q   <= acc_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            sof_q   <= sof_d;
            eof_q   <= eof_d;
        end
    end

    assign bus.dout       = dout_q;
    assign bus.dout_valid = valid_q;
    assign bus.dout_sof   = sof_q;
    assign bus.dout_eof   = eof_q;
    assign seq_num        = seq_q;
    assign sync_err       = err_q;
endmodule

// File: doc/tge_frame_packer.md
# tge_frame_packer

Upstream feeder for the 10GbE write packetizer. It packs a stream of 32-bit detector samples into 128-bit words. Ahead of each packet's payload it inserts one 128-bit header word carrying a magic tag, a sequence number and a cycle timestamp. Its output stream drives the packetizer's 128-bit `din`/`din_valid` input directly. Packet framing is sync-aligned, and the output can never be back-pressured.

## Interface
- `MAGIC`, 32'hF2B0_0001, constant placed in header bits [127:96]
- `clk`  in  1  sole clock
- `rst_n`  in  1  asynchronous, active-low reset
- `enable`  in  1  run request; sampled only at packet boundaries
- `sync_in`  in  1  single-cycle frame-start pulse
- `din`  in  32  sample
- `din_valid`  in  1  sample strobe; at most one sample per cycle
- `words_per_pkt`  in  16  payload words (128-bit) per packet, excluding header; 0 is treated as 1
- `dout`  out  128  header or packed payload word
- `dout_valid`  out  1  `dout` qualifier
- `dout_sof`  out  1  high with the header word
- `dout_eof`  out  1  high with the last payload word of a packet
- `seq_num`  out  32  sequence number of the packet currently open
- `sync_err`  out  1  sticky flag for a misaligned `sync_in` while in RUN

## Operation
- **Reset.** All outputs are 0 and the state is IDLE. Lane, word and timestamp counters are 0.
- **States.**
  - IDLE: moves to WAIT_SYNC when `enable`=1.
  - WAIT_SYNC: moves to RUN on `sync_in`=1. In the same cycle it clears the timestamp counter to 0, `seq_num` to 0, and the lane and word counters to 0. If `enable` drops while in WAIT_SYNC, return to IDLE.
  - RUN: samples are accepted. After the eof word, go to IDLE if `enable`=0, otherwise stay in RUN and open the next packet.
- **Sample acceptance.** A sample is accepted only in RUN, or in the WAIT_SYNC cycle where `sync_in`=1. That sync-cycle sample becomes sample 0 of packet 0. Samples in IDLE, and samples in WAIT_SYNC without sync, are dropped silently.
- **Timestamp.** A 64-bit counter increments every cycle and wraps modulo 2^64. Its value is 0 in the sync cycle.
- **Header emission.** The header is emitted when sample 0 of a packet is accepted: lane=0 and word=0.
  - Fields: [127:96]=`MAGIC`, [95:64]=`seq_num`, [63:0]=timestamp in the acceptance cycle.
  - `words_per_pkt` is latched at the same moment. Changes mid-packet have no effect.
- **Packing.**
  - Lane order: sample with lane 0 goes to [127:96], lane 1 to [95:64], lane 2 to [63:32], lane 3 to [31:0].
  - The lane counter wraps 3→0.
  - The fourth sample completes a payload word and increments the word counter.
- **End of packet.**
  - The payload word with index latched_len−1 carries `dout_eof`.
  - The word counter then returns to 0, and `seq_num` increments (32-bit wrap) on that same edge.
- **Collision freedom.** The header cycle (lane 0) and the payload cycle (lane 3) are always distinct cycles, so no buffering is needed.
- **Output words per packet.** Each packet produces latched_len+1 output words.
- **Sync in RUN.**
  - At a packet boundary (lane=0, word=0), `sync_in` is ignored.
  - Anywhere else, it sets `sync_err`, which stays set until reset.
  - In both cases framing, timestamp and `seq_num` are unaffected.
- **Enable deasserted mid-packet.** The packet completes normally, and only then does the block go to IDLE.

## Timing
- Latency is 1 cycle, with all outputs registered:
  - The header appears on `dout` the cycle after sample 0 is accepted.
  - A payload word appears the cycle after its lane-3 sample.
- `dout_valid`, `dout_sof` and `dout_eof` are single-cycle pulses.
- `dout_sof` and `dout_eof` are never high together.
- Output throughput is at most 2 valid words per 4 input samples, and at most one valid word per cycle.
- `dout` holds its last value when `dout_valid`=0.
- `rst_n` low at any time forces the reset state immediately (asynchronously). Any partial word is lost, and no eof is issued.
- The first accepted sample after reset requires a fresh `sync_in`.

## Test plan
- **Nominal single packet.** Reset, `enable`=1, `words_per_pkt`=2, `sync_in` with `din`=1 in the same cycle, then `din`=2..8 back-to-back. Required: header {F2B0_0001, 0, 0} with sof one cycle after sync; payload {1,2,3,4} at +4 cycles; payload {5,6,7,8} with eof at +8 cycles; `seq_num`=1 afterwards.
- **Gapped input.** `din_valid` toggling 1/0 for 2 packets, `words_per_pkt`=1. Required: the header timestamp of packet 1 equals its acceptance cycle count (8 for this pattern); `seq_num` field reads 1; each packet is 2 words.
- **Pre-sync drop.** 5 samples before `sync_in`. Required: no `dout_valid`; the first header's timestamp is 0.
- **Misaligned sync.** `sync_in` at lane 2 in RUN. Required: `sync_err`=1 and framing unchanged. `sync_in` exactly at a boundary: `sync_err` stays 0.
- **Enable drop mid-packet.** `words_per_pkt`=3, with `enable` deasserted after word 1. Required: words 2 and 3 still arrive, eof on word 3, then IDLE and further samples ignored.
- **Length edge and async reset.** `words_per_pkt`=0. Required: header plus 1 payload word with eof. Also: `rst_n` low mid-word clears all outputs without waiting for a `clk` edge.
